// File: rtl/alu_bit31.sv
// Most-significant bit slice of a 32-bit ALU: AND/OR/ADD/SLT with overflow detect.
// Latency: one core cycle from accepted inputs to registered result/carryOut/overflow; set is combinational.
// Backpressure: none; in_valid is accepted every cycle, and outputs hold while in_valid is low.
module alu_bit31 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       invertA,
  input  logic       invertB,
  input  logic [1:0] operation,
  input  logic       carryIn,
  input  logic       less,
  input  logic       in_valid,
  output logic       result,
  output logic       carryOut,
  output logic       set,
  output logic       overflow,
  output logic       out_valid
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  logic ai;
  logic bi;
  logic sum;
  logic cout;

  logic result_d,    result_q;
  logic carry_out_d, carry_out_q;
  logic overflow_d,  overflow_q;
  logic out_valid_d, out_valid_q;

  // Operand conditioning and full adder; set exposes the raw sum so bit 0 can use it for SLT.
  always_comb begin
    ai   = a ^ invertA;
    bi   = b ^ invertB;
    sum  = ai ^ bi ^ carryIn;
    cout = (ai & bi) | (ai & carryIn) | (bi & carryIn);
  end

  assign set = sum;

  // Next-state selection: load on in_valid, otherwise hold data and drop out_valid.
  always_comb begin
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_valid_d = 1'b1;
      carry_out_d = cout;
      // Overflow only means something for the arithmetic ops (ADD and the subtract behind SLT).
      overflow_d  = (operation == OP_ADD || operation == OP_SLT) ? (carryIn ^ cout) : 1'b0;
      case (operation)
        OP_AND:  result_d = ai & bi;
        OP_OR:   result_d = ai | bi;
        OP_ADD:  result_d = sum;
        OP_SLT:  result_d = less;
        default: result_d = 1'b0;
      endcase
    end
  end

  // Output registers with asynchronous clear; a reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign carryOut  = carry_out_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_bit31.sv
// Directed-vector bench for the ALU MSB slice.
// Checks set immediately after driving, registered outputs 1ns after the capturing edge.
// Covers reset, each op, overflow gating, hold, async reset and mid-stream reset.
module tb_alu_bit31;

  logic       clk;
  logic       rst_n;
  logic       a, b, invertA, invertB;
  logic [1:0] operation;
  logic       carryIn, less, in_valid;
  logic       result, carryOut, set, overflow, out_valid;

  int total = 0;
  int bad   = 0;

  alu_bit31 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .invertA   (invertA),
    .invertB   (invertB),
    .operation (operation),
    .carryIn   (carryIn),
    .less      (less),
    .in_valid  (in_valid),
    .result    (result),
    .carryOut  (carryOut),
    .set       (set),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one valid vector at the falling edge, check set, then registered outputs after the rise.
  task automatic run_vec(input string tag,
                         input logic va, input logic vb, input logic via, input logic vib,
                         input logic [1:0] vop, input logic vcin, input logic vless,
                         input logic e_set, input logic e_res, input logic e_co, input logic e_ov);
    @(negedge clk);
    a = va; b = vb; invertA = via; invertB = vib;
    operation = vop; carryIn = vcin; less = vless; in_valid = 1'b1;
    #1;
    chk({tag, ".set"}, set, e_set);
    @(posedge clk);
    #1;
    chk({tag, ".result"},    result,    e_res);
    chk({tag, ".carryOut"},  carryOut,  e_co);
    chk({tag, ".overflow"},  overflow,  e_ov);
    chk({tag, ".out_valid"}, out_valid, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    a = 1'b1; b = 1'b0; invertA = 1'b0; invertB = 1'b0;
    operation = 2'b10; carryIn = 1'b0; less = 1'b0; in_valid = 1'b0;

    // Reset state; set stays combinational during reset.
    #2;
    chk("rst.result",    result,    1'b0);
    chk("rst.carryOut",  carryOut,  1'b0);
    chk("rst.overflow",  overflow,  1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.set",       set,       1'b1);
    b = 1'b1;
    #1;
    chk("rst.set2",      set,       1'b0);
    @(posedge clk);
    #1;
    chk("rst.hold_result", result, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // SLT with invertB and carryIn=1 (subtract), back-to-back.
    //        tag       a     b     iA    iB    op     cin   less  set   res   co    ov
    run_vec("slt00", 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_vec("slt01", 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_vec("slt10", 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("slt11", 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ADD.
    run_vec("add110", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_vec("add011", 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // AND/OR; the third vector produces cout=1 with cin=0 to show overflow is gated off.
    run_vec("and10",   1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_vec("or10",    1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_vec("and10ib", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_vec("or11ia",  1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // less passthrough regardless of operands.
    run_vec("less11", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_vec("less00", 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Hold: known state result=1, carryOut=1, overflow=1; drop in_valid and wiggle inputs.
    run_vec("pre_hold", 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; a = 1'b0; b = 1'b0; operation = 2'b00; less = 1'b0;
    @(posedge clk);
    #1;
    chk("hold.result",    result,    1'b1);
    chk("hold.carryOut",  carryOut,  1'b1);
    chk("hold.overflow",  overflow,  1'b1);
    chk("hold.out_valid", out_valid, 1'b0);
    @(negedge clk);
    a = 1'b1; b = 1'b1;
    @(posedge clk);
    #1;
    chk("hold2.result",   result,    1'b1);
    chk("hold2.out_valid", out_valid, 1'b0);

    // Async reset between edges while a valid operation is pending.
    run_vec("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    a = 1'b1; b = 1'b1; operation = 2'b10; carryIn = 1'b0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.result",    result,    1'b0);
    chk("arst.carryOut",  carryOut,  1'b0);
    chk("arst.overflow",  overflow,  1'b0);
    chk("arst.out_valid", out_valid, 1'b0);
    chk("arst.set",       set,       1'b0);
    @(posedge clk);
    #1;
    chk("arst.drop_valid",  out_valid, 1'b0);
    chk("arst.drop_result", carryOut,  1'b0);

    // First valid edge after reset release loads normally (1+1+0: sum 0, cout 1, ov 1).
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post.result",    result,    1'b0);
    chk("post.carryOut",  carryOut,  1'b1);
    chk("post.overflow",  overflow,  1'b1);
    chk("post.out_valid", out_valid, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post.valid_drop", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_bit31.md
ALU_BIT31 -- requirements
Module: alu_bit31

Interface
REQ-001 SHALL have no parameters; all data paths are 1 bit wide, operation is 2 bits.
REQ-002 clk  input  1  rising-edge clock for all registered outputs.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  1  operand A bit (MSB, bit 31, of the word).
REQ-005 b  input  1  operand B bit (MSB).
REQ-006 invertA  input  1  1 = use ~a internally.
REQ-007 invertB  input  1  1 = use ~b internally.
REQ-008 operation  input  2  00 AND, 01 OR, 10 ADD, 11 SLT.
REQ-009 carryIn  input  1  carry from bit 30.
REQ-010 less  input  1  value placed on result when operation=11.
REQ-011 in_valid  input  1  qualifies inputs this cycle.
REQ-012 result  output  1  registered selected result bit.
REQ-013 carryOut  output  1  registered adder carry-out.
REQ-014 set  output  1  combinational adder sum bit (SLT source for bit 0).
REQ-015 overflow  output  1  registered signed overflow flag.
REQ-016 out_valid  output  1  registered; high one cycle after an accepted in_valid.

Function
REQ-017 Internal operands SHALL be ai = a ^ invertA, bi = b ^ invertB.
REQ-018 Full adder: sum = ai ^ bi ^ carryIn; cout = (ai & bi) | (ai & carryIn) | (bi & carryIn).
REQ-019 set SHALL equal sum combinationally for every operation, with no clock dependency.
REQ-020 Next result: 00 -> ai & bi; 01 -> ai | bi; 10 -> sum; 11 -> less.
REQ-021 Next carryOut SHALL be cout for every operation code.
REQ-022 Next overflow SHALL be carryIn ^ cout when operation is 10 or 11, else 0.
REQ-023 On a rising clk with in_valid=1, result, carryOut and overflow SHALL load their next values, and out_valid SHALL be set to 1.
REQ-024 On a rising clk with in_valid=0, result, carryOut and overflow SHALL hold their values, and out_valid SHALL be cleared to 0.
REQ-025 Latency SHALL be exactly one clock from inputs to registered outputs; back-to-back in_valid SHALL be accepted every cycle.
REQ-026 No X propagation: all outputs SHALL be a defined 0/1 whenever inputs are defined.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force result=0, carryOut=0, overflow=0 and out_valid=0.
REQ-028 While rst_n=0, registered outputs SHALL stay 0; set SHALL remain combinational and valid.
REQ-029 After rst_n deasserts, the first rising clk with in_valid=1 SHALL load normal values.
REQ-030 Reset asserted mid-stream SHALL discard the pending operation; out_valid SHALL not pulse for it.

Verification
REQ-031 SLT, operation=11, invertA=0, invertB=1, carryIn=1, less=0, in_valid=1, (a,b) = 00/01/10/11 -> set = 0/1/1/0 immediately; carryOut = 1/0/1/1, result = 0 and out_valid = 1 after the next clk edge.
REQ-032 ADD, operation=10, invert=00, a=1, b=1, carryIn=0 -> result=0, carryOut=1, overflow=1 after 1 clk; a=0, b=1, carryIn=1 -> result=0, carryOut=1, overflow=0.
REQ-033 AND/OR, a=1, b=0: op 00 -> result 0; op 01 -> result 1; op 00 with invertB=1 -> result 1; overflow=0 in all cases.
REQ-034 less passthrough, op=11, less=1 -> result=1 regardless of a and b.
REQ-035 Hold/valid: load a value, drop in_valid, toggle a and b -> registered outputs unchanged and out_valid=0.
REQ-036 Async reset: assert rst_n=0 between clk edges with result=1 -> all registered outputs 0 before the next edge.
